// File: rtl/ocd_reply_tx.sv
// OCD reply transmitter: frames a 32-bit reply word onto a UART line.
// Optional checksum trailer is compiled in with OCD_REPLY_CHECKSUM_EN.
module ocd_reply_tx #(
  parameter int BAUD_PERIOD = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  output logic        word_ready,
  input  logic        abort,
  output logic        TXD,
  output logic        tx_active,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] RELOAD = 16'(BAUD_PERIOD - 1);

`ifdef OCD_REPLY_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd7;
`else
  localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

  state_t      state;
  logic [31:0] word_q;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic        rdy_q;
  logic [7:0]  cur_byte;
  logic        baud_end;

`ifdef OCD_REPLY_CHECKSUM_EN
  logic [15:0] csum;

  // Trailer: 16-bit sum of the four payload bytes
  always_comb begin
    csum = 16'(word_q[31:24])
         + 16'(word_q[23:16])
         + 16'(word_q[15:8])
         + 16'(word_q[7:0]);
  end
`endif

  assign baud_end = (baud_cnt == 16'd0);

  // Ready only while idle, armed, and not being aborted
  assign word_ready = rdy_q & ~abort
                    & (state == IDLE);

  // Select the byte currently on the wire
  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      3'd0: cur_byte = 8'h5A;
      3'd1: cur_byte = 8'hA5;
      3'd2: cur_byte = word_q[31:24];
      3'd3: cur_byte = word_q[23:16];
      3'd4: cur_byte = word_q[15:8];
      3'd5: cur_byte = word_q[7:0];
`ifdef OCD_REPLY_CHECKSUM_EN
      3'd6: cur_byte = csum[15:8];
      3'd7: cur_byte = csum[7:0];
`endif
      default: cur_byte = 8'hFF;
    endcase
  end

  // Frame sequencer with registered line and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_q     <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      rdy_q      <= 1'b0;
      TXD        <= 1'b1;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        baud_cnt  <= '0;
        bit_idx   <= '0;
        byte_idx  <= '0;
        rdy_q     <= 1'b1;
        TXD       <= 1'b1;
        tx_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            TXD <= 1'b1;
            if (rdy_q && word_valid) begin
              word_q    <= word_in;
              state     <= START;
              baud_cnt  <= RELOAD;
              bit_idx   <= '0;
              byte_idx  <= '0;
              rdy_q     <= 1'b0;
              TXD       <= 1'b0;
              tx_active <= 1'b1;
            end else begin
              rdy_q     <= 1'b1;
              tx_active <= 1'b0;
            end
          end
          START: begin
            if (baud_end) begin
              state    <= DATA;
              baud_cnt <= RELOAD;
              bit_idx  <= '0;
              TXD      <= cur_byte[0];
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          DATA: begin
            if (baud_end) begin
              baud_cnt <= RELOAD;
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
                TXD   <= 1'b1;
              end else begin
                TXD <= cur_byte[bit_idx + 3'd1];
              end
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          STOP: begin
            if (baud_end) begin
              if (byte_idx == LAST_BYTE) begin
                state      <= IDLE;
                byte_idx   <= '0;
                baud_cnt   <= '0;
                TXD        <= 1'b1;
                frame_done <= 1'b1;
              end else begin
                state    <= START;
                byte_idx <= byte_idx + 3'd1;
                baud_cnt <= RELOAD;
                TXD      <= 1'b0;
              end
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          default: begin
            state <= IDLE;
            TXD   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ocd_reply_tx.sv
// Self-checking bench for ocd_reply_tx with BAUD_PERIOD=4.
// Frame bits are predicted from byte list and bit timing arithmetic.
module tb_ocd_reply_tx;

  localparam int BP = 4;
`ifdef OCD_REPLY_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME = NB * 10 * BP;

  logic        clk;
  logic        reset;
  logic        word_valid;
  logic [31:0] word_in;
  logic        word_ready;
  logic        abort;
  logic        TXD;
  logic        tx_active;
  logic        frame_done;

  int errors;
  int checks;
  int cyc;
  int last_start;
  int last_done;

  ocd_reply_tx #(.BAUD_PERIOD(BP)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_valid (word_valid),
    .word_in    (word_in),
    .word_ready (word_ready),
    .abort      (abort),
    .TXD        (TXD),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    logic [15:0] s;
    s = 16'(w[31:24]) + 16'(w[23:16]) + 16'(w[15:8]) + 16'(w[7:0]);
    case (i)
      0: return 8'h5A;
      1: return 8'hA5;
      2: return w[31:24];
      3: return w[23:16];
      4: return w[15:8];
      5: return w[7:0];
      6: return s[15:8];
      7: return s[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int b;
    int p;
    logic [7:0] v;
    b = k / (10 * BP);
    p = (k / BP) % 10;
    v = exp_byte(w, b);
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return v[p-1];
  endfunction

  task automatic accept(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (word_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: word_ready=%b after %0d cycles, want 1", word_ready, n);
    end
    word_valid = 1'b1;
    word_in = w;
    @(posedge clk);
    #1;
  endtask

  // Starts right after the acceptance edge; ends on the negedge after frame_done
  task automatic check_frame(input logic [31:0] w, input bit scramble);
    int berr[8];
    int act_bad;
    int done_bad;
    int rdy_bad;
    act_bad = 0;
    done_bad = 0;
    rdy_bad = 0;
    for (int i = 0; i < 8; i++) berr[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        last_start = cyc;
        checks++;
        if (TXD !== 1'b0) begin
          errors++;
          $display("FAIL first_start_bit: TXD=%b want 0", TXD);
        end
      end
      if (TXD !== exp_bit(w, k)) berr[k / (10 * BP)]++;
      if (tx_active !== 1'b1) act_bad++;
      if (frame_done !== 1'b0) done_bad++;
      if (word_ready !== 1'b0) rdy_bad++;
      if (scramble) word_in = $urandom;
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (berr[b] != 0) begin
        errors++;
        $display("FAIL byte%0d word=%h: %0d bad bit-cycles, want byte %h",
                 b, w, berr[b], exp_byte(w, b));
      end
    end
    checks++;
    if (act_bad != 0) begin
      errors++;
      $display("FAIL tx_active_in_frame: %0d low cycles, want 0", act_bad);
    end
    checks++;
    if (done_bad != 0) begin
      errors++;
      $display("FAIL early_frame_done: %0d pulses, want 0", done_bad);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL ready_in_frame: %0d ready cycles, want 0", rdy_bad);
    end
    @(negedge clk);
    last_done = cyc;
    checks++;
    if (frame_done !== 1'b1 || tx_active !== 1'b1 || TXD !== 1'b1 || word_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: done=%b act=%b txd=%b rdy=%b want 1 1 1 0",
               frame_done, tx_active, TXD, word_ready);
    end
    checks++;
    if (last_done - last_start != FRAME) begin
      errors++;
      $display("FAIL done_latency: %0d cycles want %0d", last_done - last_start, FRAME);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || tx_active !== 1'b0 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_done: done=%b act=%b rdy=%b want 0 0 1",
               frame_done, tx_active, word_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    word_valid = 1'b0;
    word_in = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (TXD !== 1'b1 || word_ready !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: txd=%b rdy=%b act=%b done=%b want 1 0 0 0",
               TXD, word_ready, tx_active, frame_done);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: %b want 1", word_ready);
    end
  endtask

  task automatic test_basic;
    accept(32'h12345678);
    word_valid = 1'b0;
    check_frame(32'h12345678, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      accept(w);
      word_valid = 1'b0;
      check_frame(w, 1'b0);
    end
  endtask

  task automatic test_scramble;
    logic [31:0] w;
    w = $urandom;
    accept(w);
    word_valid = 1'b0;
    check_frame(w, 1'b1);
  endtask

  task automatic test_back_to_back;
    int first_done;
    accept(32'hDEADBEEF);
    word_in = 32'h00000001;
    check_frame(32'hDEADBEEF, 1'b0);
    first_done = last_done;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    check_frame(32'h00000001, 1'b0);
    checks++;
    if (last_start - first_done < 2) begin
      errors++;
      $display("FAIL b2b_gap: start %0d cycles after done, want >=2",
               last_start - first_done);
    end
  endtask

  task automatic test_abort;
    int bad;
    logic [31:0] w;
    w = $urandom;
    accept(w);
    word_valid = 1'b0;
    repeat (127) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (TXD !== 1'b1 || tx_active !== 1'b0 || word_ready !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: txd=%b act=%b rdy=%b done=%b want 1 0 0 0",
               TXD, tx_active, word_ready, frame_done);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (TXD !== 1'b1 || word_ready !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_held: %0d bad cycles want 0", bad);
    end
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort: %b want 1", word_ready);
    end
    bad = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (TXD !== 1'b1 || frame_done !== 1'b0 || tx_active !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d bad cycles want 0", bad);
    end
    // abort wins over an offered word in IDLE
    abort = 1'b1;
    word_valid = 1'b1;
    word_in = $urandom;
    @(negedge clk);
    checks++;
    if (tx_active !== 1'b0 || TXD !== 1'b1 || word_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: act=%b txd=%b rdy=%b want 0 1 0",
               tx_active, TXD, word_ready);
    end
    abort = 1'b0;
    word_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_active !== 1'b0 || TXD !== 1'b1 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_priority_after: act=%b txd=%b rdy=%b want 0 1 1",
               tx_active, TXD, word_ready);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] w;
    w = $urandom;
    accept(w);
    word_valid = 1'b0;
    repeat (82) @(negedge clk);
    checks++;
    if (TXD !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_start_bit: TXD=%b want 0", TXD);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (TXD !== 1'b1 || word_ready !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: txd=%b rdy=%b act=%b done=%b want 1 0 0 0",
               TXD, word_ready, tx_active, frame_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: %b want 0", word_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset: %b want 1", word_ready);
    end
    w = $urandom;
    accept(w);
    word_valid = 1'b0;
    check_frame(w, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    last_start = 0;
    last_done = 0;
    test_reset();
    test_basic();
    test_random();
    test_scramble();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocd_reply_tx.md
OCD_REPLY_TX -- requirements
Module: ocd_reply_tx

Interface
REQ-001 SHALL have parameter BAUD_PERIOD, default 104, meaning clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port word_valid  input  1  reply word offered.
REQ-005 SHALL have port word_in  input  32 (`XLEN)  reply word, e.g. PRAM read data.
REQ-006 SHALL have port word_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port abort  input  1  synchronous frame abort.
REQ-008 SHALL have port TXD  output  1  UART serial out, 8N1, idle high.
REQ-009 SHALL have port tx_active  output  1  frame in progress.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-011 SHALL accept a word on any rising edge with word_valid=1 and word_ready=1, latching word_in.
REQ-012 SHALL assert word_ready only in IDLE with abort=0; word_in is ignored at all other times.
REQ-013 SHALL transmit frame bytes in order 0x5A, 0xA5, word[31:24], word[23:16], word[15:8], word[7:0].
REQ-014 SHALL send each byte as start bit 0, data bits LSB first, stop bit 1, each bit exactly BAUD_PERIOD cycles.
REQ-015 SHALL drive TXD from a register; the start bit of byte 0 appears on TXD the cycle after acceptance.
REQ-016 SHALL insert no idle time between consecutive bytes of a frame.
REQ-017 SHALL use FSM states IDLE, START, DATA, STOP with transitions:
- IDLE->START on acceptance.
- START->DATA after BAUD_PERIOD cycles.
- DATA->STOP after 8 bits.
- STOP->START if more bytes remain, else STOP->IDLE.
REQ-018 SHALL use a baud counter reloaded at each bit boundary, a 3-bit bit index that wraps 7->0, and a byte index.
REQ-019 SHALL pulse frame_done for one cycle on the STOP->IDLE transition; word_ready re-asserts the following cycle, giving at least 1 idle cycle between frames.
REQ-020 SHALL hold tx_active=1 from the cycle after acceptance until the frame_done cycle inclusive.
REQ-021 SHALL, on abort=1 in any state, go to IDLE next cycle with TXD=1, no frame_done pulse, and word_ready=0 while abort is held.
REQ-022 SHALL give abort priority when abort and word_valid are both asserted in IDLE; no word is accepted.

Reset
REQ-023 SHALL, while reset=1, force state IDLE, TXD=1, word_ready=0, tx_active=0, frame_done=0, and all counters to 0.
REQ-024 SHALL, when reset asserts mid-frame, force TXD=1 immediately (asynchronously) and discard the latched word.
REQ-025 SHALL assert word_ready on the first clk edge after reset deasserts.

Configuration
REQ-026 SHALL compile in a checksum trailer when macro OCD_REPLY_CHECKSUM_EN is defined.
REQ-027 SHALL, with OCD_REPLY_CHECKSUM_EN defined, append 2 bytes after word[7:0]: the 16-bit sum of the 4 data bytes, MSB first (8-byte frame).
REQ-028 SHALL, without OCD_REPLY_CHECKSUM_EN, send a 6-byte frame and contain no checksum logic.

Verification (BAUD_PERIOD=4)
REQ-029 SHALL cover: accept 0x12345678, macro off -> bytes 5A A5 12 34 56 78 on TXD; TXD low the cycle after acceptance; frame_done exactly 240 cycles after the first start-bit cycle.
REQ-030 SHALL cover: same word, macro on -> trailer bytes 0x01 0x14; frame_done 320 cycles after the first start bit.
REQ-031 SHALL cover: word_valid held high across two words 0xDEADBEEF then 0x00000001 -> two frames; second start bit no earlier than 1 idle cycle after the first frame_done; second word latched only at its acceptance.
REQ-032 SHALL cover: abort during DATA of byte 3 -> TXD=1 next cycle, no frame_done, word_ready=1 the cycle after abort drops.
REQ-033 SHALL cover: reset pulse mid-frame -> TXD=1 within the reset cycle, all outputs at reset values; a new frame transmits correctly afterwards.
REQ-034 SHALL cover: word_in changes every cycle during a frame -> transmitted bytes equal the word latched at acceptance.
